// File: rtl/bram_blit_engine.sv
// Block copy/fill engine driving one port of a pipelined dual-port block RAM.
// Copies are memmove-safe (direction chosen from overlap); fills stream one word per cycle.
module bram_blit_engine #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_fill,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] cmd_pattern,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              done_aborted,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]        WAIT_LAST = 3'(RD_LATENCY - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] src_ptr_reg, src_ptr_next;
  logic [ADDR_W-1:0] dst_ptr_reg, dst_ptr_next;
  logic [ADDR_W:0]   remain_reg, remain_next;
  logic [2:0]        wait_cnt_reg, wait_cnt_next;
  logic [DATA_W-1:0] hold_reg, hold_next;
  logic [DATA_W-1:0] pattern_reg, pattern_next;
  logic [DATA_W-1:0] din_last_reg, din_last_next;
  logic [ADDR_W-1:0] addr_last_reg, addr_last_next;
  logic              fill_reg, fill_next;
  logic              desc_reg, desc_next;
  logic              aborted_reg, aborted_next;

  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W-1:0] len_m1;
  logic [ADDR_W-1:0] dst_diff;
  logic              cmd_desc;

  // Descending order is only needed when the destination overlaps the tail of the source.
  always_comb begin
    len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    len_m1      = len_clamped[ADDR_W-1:0] - PTR_ONE;
    dst_diff    = cmd_dst - cmd_src;
    cmd_desc    = !cmd_fill && (cmd_dst > cmd_src) && ({1'b0, dst_diff} < len_clamped);
  end

  always_comb begin
    state_next    = state_reg;
    src_ptr_next  = src_ptr_reg;
    dst_ptr_next  = dst_ptr_reg;
    remain_next   = remain_reg;
    wait_cnt_next = wait_cnt_reg;
    hold_next     = hold_reg;
    pattern_next  = pattern_reg;
    fill_next     = fill_reg;
    desc_next     = desc_reg;
    aborted_next  = aborted_reg;
    ram_ce        = 1'b0;
    ram_oce       = 1'b0;
    ram_wre       = 1'b0;
    ram_addr      = addr_last_reg;
    ram_din       = din_last_reg;
    done          = 1'b0;
    done_aborted  = 1'b0;
    cmd_ready     = 1'b0;
    busy          = 1'b0;

    case (state_reg)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          fill_next     = cmd_fill;
          pattern_next  = cmd_pattern;
          remain_next   = len_clamped;
          desc_next     = cmd_desc;
          aborted_next  = 1'b0;
          wait_cnt_next = 3'd0;
          src_ptr_next  = cmd_desc ? cmd_src + len_m1 : cmd_src;
          dst_ptr_next  = cmd_desc ? cmd_dst + len_m1 : cmd_dst;
          if (len_clamped == '0) begin
            state_next = S_DONE;
          end else if (cmd_fill) begin
            state_next = S_WR;
          end else begin
            state_next = S_RD;
          end
        end
      end

      S_RD: begin
        busy          = 1'b1;
        ram_ce        = 1'b1;
        ram_oce       = 1'b1;
        ram_addr      = src_ptr_reg;
        wait_cnt_next = 3'd0;
        if (abort) begin
          aborted_next = 1'b1;
          state_next   = S_DONE;
        end else begin
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        busy     = 1'b1;
        ram_ce   = 1'b1;
        ram_oce  = 1'b1;
        ram_addr = src_ptr_reg;
        if (abort) begin
          aborted_next = 1'b1;
          state_next   = S_DONE;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          hold_next  = ram_dout;
          state_next = S_WR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 3'd1;
        end
      end

      S_WR: begin
        busy        = 1'b1;
        ram_ce      = 1'b1;
        ram_wre     = 1'b1;
        ram_addr    = dst_ptr_reg;
        ram_din     = fill_reg ? pattern_reg : hold_reg;
        remain_next = remain_reg - LEN_ONE;
        if (desc_reg) begin
          src_ptr_next = src_ptr_reg - PTR_ONE;
          dst_ptr_next = dst_ptr_reg - PTR_ONE;
        end else begin
          src_ptr_next = src_ptr_reg + PTR_ONE;
          dst_ptr_next = dst_ptr_reg + PTR_ONE;
        end
        // An abort here still lets this write land; it only stops further words.
        if (abort) begin
          aborted_next = 1'b1;
          state_next   = S_DONE;
        end else if (remain_reg == LEN_ONE) begin
          state_next = S_DONE;
        end else if (fill_reg) begin
          state_next = S_WR;
        end else begin
          state_next = S_RD;
        end
      end

      S_DONE: begin
        done         = 1'b1;
        done_aborted = aborted_reg;
        state_next   = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    addr_last_next = ram_addr;
    din_last_next  = ram_din;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= S_IDLE;
      src_ptr_reg   <= '0;
      dst_ptr_reg   <= '0;
      remain_reg    <= '0;
      wait_cnt_reg  <= '0;
      hold_reg      <= '0;
      pattern_reg   <= '0;
      din_last_reg  <= '0;
      addr_last_reg <= '0;
      fill_reg      <= 1'b0;
      desc_reg      <= 1'b0;
      aborted_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      src_ptr_reg   <= src_ptr_next;
      dst_ptr_reg   <= dst_ptr_next;
      remain_reg    <= remain_next;
      wait_cnt_reg  <= wait_cnt_next;
      hold_reg      <= hold_next;
      pattern_reg   <= pattern_next;
      din_last_reg  <= din_last_next;
      addr_last_reg <= addr_last_next;
      fill_reg      <= fill_next;
      desc_reg      <= desc_next;
      aborted_reg   <= aborted_next;
    end
  end

endmodule
